router_dest_reader: RTL and testbench
=====================================

// Module: router_dest_reader
// PURPOSE
// - Destination-side reader for one router output port; one instance per port.
// - Consumes packets that the synchroniser advertises with vld_outN.
// - Drives the matching read enable (reN) into that port's FIFO.
// - Parses the header, drains payload and parity, checks parity and address.
// - Streams received bytes to the local sink and reports per-packet status.
// - Sits at the far end of the synchroniser's vld_out/re/soft_reset handshake.
// PARAMETERS
// - DATA_W      8  : FIFO byte width. Header layout is len = [7:2], addr = [1:0].
// - MY_ADDR     0  : Port index (0..2) expected in the header address field.
// - WAIT_CYCLES 4  : Idle cycles between seeing vld_out and first read enable.
//                    Range 0..28, so reading always starts before the synchroniser's 30-cycle soft reset.
// PORTS
// - clk         in   1       Single clock; everything is rising-edge.
// - resetn      in   1       Asynchronous, active-low reset.
// - vld_out     in   1       FIFO holds data (from synchroniser).
// - soft_reset  in   1       Synchroniser timeout flush for this port.
// - data_out    in   DATA_W  FIFO read data, valid 1 cycle after a read_enb cycle.
// - read_enb    out  1       FIFO read strobe (feeds reN).
// - rx_data     out  DATA_W  Received byte (header, payload or parity).
// - rx_valid    out  1       rx_data is valid this cycle.
// - pkt_len     out  6       Length field of the current/last packet.
// - busy        out  1       FSM is not in IDLE.
// - pkt_done    out  1       1-cycle pulse: packet fully received.
// - pkt_abort   out  1       1-cycle pulse: packet dropped by soft_reset.
// - parity_err  out  1       Valid with pkt_done.
// - addr_err    out  1       Valid with pkt_done.
// BEHAVIOUR
// - Reset: all outputs are 0, state is IDLE, counters are 0.
// - States: IDLE -> WAIT -> READ -> DONE -> IDLE.
// - IDLE: on vld_out=1, go to WAIT and load wcnt = WAIT_CYCLES.
//   With WAIT_CYCLES=0, go straight to READ.
// - WAIT: wcnt decrements each cycle. At wcnt=0 go to READ.
//   If vld_out=0 before then, return to IDLE with no pulse.
// - READ, read issue:
//   - read_enb = vld_out & (issued < total). A low vld_out stalls issue; it is not an error.
//   - total is 2 until the header arrives, then len+2 (header + len payload + parity).
//   - len=0 is legal: 2 bytes. The two reads already issued are exactly correct; no over-read.
// - READ, capture:
//   - rx_valid = read_enb registered (1-cycle latency); rx_data = data_out in that cycle.
//   - Byte 0 is the header: latch pkt_len and the addr field.
//   - Bytes 1..len are payload; byte len+1 is parity.
//   - par_acc = XOR of header and all payload bytes.
// - READ exit: after the last byte is captured (received == total), go to DONE.
// - DONE, for one cycle:
//   - pkt_done=1.
//   - parity_err = (par_acc != parity byte).
//   - addr_err = (addr != MY_ADDR).
//   - Then return to IDLE. pkt_len, parity_err and addr_err hold until the next header.
// - Back-to-back: IDLE samples vld_out in the cycle after DONE. The next packet is read with no lost bytes.
// - soft_reset=1 in WAIT, READ or DONE:
//   - Next cycle: IDLE, read_enb=0, counters cleared, pkt_abort=1.
//   - An rx_valid from a read already in flight still appears once.
//   - No pkt_done. In DONE, soft_reset takes priority over pkt_done.
// - soft_reset in IDLE is ignored.
// - resetn low mid-packet: immediate asynchronous return to reset values.
// - Counter widths: issued and received are 7 bits; max total is 65.
// STRUCTURE
// - Shared include router_defs.vh holds:
//   - HDR_LEN_MSB/LSB and HDR_ADDR_MSB/LSB.
//   - State encodings (2-bit).
//   - SOFT_RESET_TIMEOUT=30, shared with the synchroniser.
// - Single flat module; no sub-module. Parity accumulator and wait counter are inline.
// TESTING
// 1. Reset, then vld_out=1, WAIT_CYCLES=4, packet hdr 8'h0C (len3, addr0) + 11,22,33, parity = 0C^11^22^33.
//    -> read_enb first high 5 cycles after vld_out rises, high for 5 cycles; rx_valid 5 cycles;
//       pkt_done=1, parity_err=0, addr_err=0, pkt_len=3.
// 2. Same packet, parity byte corrupted to 8'h00 -> pkt_done with parity_err=1, rx_data shows all 5 bytes.
// 3. Header 8'h05 (len1, addr1) on MY_ADDR=0 -> 3 reads, addr_err=1.
// 4. Header 8'h00 (len0) + parity 8'h00 -> exactly 2 read_enb cycles, pkt_done, parity_err=0.
// 5. vld_out dropped for 3 cycles mid-payload -> read_enb low those 3 cycles; resume; correct byte count; pkt_done.
// 6. soft_reset pulsed during payload byte 2 of len 10 -> next cycle read_enb=0, pkt_abort=1, busy=0, no pkt_done.
//    Then a new valid packet completes normally.

Source files
------------

// File: rtl/router_dest_reader_pkg.sv
// Shared definitions for the router destination-side reader: header layout,
// FSM state encoding and counter widths.
package router_dest_reader_pkg;

    localparam int unsigned HDR_LEN_MSB        = 7;
    localparam int unsigned HDR_LEN_LSB        = 2;
    localparam int unsigned HDR_ADDR_MSB       = 1;
    localparam int unsigned HDR_ADDR_LSB       = 0;
    localparam int unsigned SOFT_RESET_TIMEOUT = 30;

    localparam int unsigned CNT_W  = 7;
    localparam int unsigned WCNT_W = 5;
    localparam int unsigned LEN_W  = 6;
    localparam int unsigned ADDR_W = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_READ = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/router_dest_reader.sv
// Destination-side packet reader for one router output port: drains a packet
// from the port FIFO, streams it to the sink and reports parity/address status.
module router_dest_reader
    import router_dest_reader_pkg::*;
#(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned MY_ADDR     = 0,
    parameter int unsigned WAIT_CYCLES = 4
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              vld_out,
    input  logic              soft_reset,
    input  logic [DATA_W-1:0] data_out,
    output logic              read_enb,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic [LEN_W-1:0]  pkt_len,
    output logic              busy,
    output logic              pkt_done,
    output logic              pkt_abort,
    output logic              parity_err,
    output logic              addr_err
);

    state_t              state;
    logic [WCNT_W-1:0]   wcnt;
    logic [CNT_W-1:0]    issued;
    logic [CNT_W-1:0]    received;
    logic [CNT_W-1:0]    total;
    logic [ADDR_W-1:0]   addr;
    logic [DATA_W-1:0]   par_acc;
    logic [DATA_W-1:0]   par_byte;

    logic                hdr_now;
    logic [CNT_W-1:0]    total_n;
    logic [CNT_W-1:0]    issued_n;
    logic [CNT_W-1:0]    received_n;

    // Header length is folded into the issue limit in the same cycle it lands,
    // so the third read follows the first two without a bubble.
    assign hdr_now    = rx_valid && (received == '0);
    assign total_n    = hdr_now ? CNT_W'(data_out[HDR_LEN_MSB:HDR_LEN_LSB]) + CNT_W'(2) : total;
    assign issued_n   = issued + CNT_W'(read_enb);
    assign received_n = received + CNT_W'(rx_valid);

    // FIFO data is already registered; expose it only while it is valid.
    assign rx_data = rx_valid ? data_out : '0;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= ST_IDLE;
            wcnt       <= '0;
            issued     <= '0;
            received   <= '0;
            total      <= '0;
            addr       <= '0;
            par_acc    <= '0;
            par_byte   <= '0;
            read_enb   <= 1'b0;
            rx_valid   <= 1'b0;
            pkt_len    <= '0;
            busy       <= 1'b0;
            pkt_done   <= 1'b0;
            pkt_abort  <= 1'b0;
            parity_err <= 1'b0;
            addr_err   <= 1'b0;
        end else begin
            rx_valid  <= read_enb;
            pkt_done  <= 1'b0;
            pkt_abort <= 1'b0;

            if (soft_reset && (state != ST_IDLE)) begin
                state     <= ST_IDLE;
                read_enb  <= 1'b0;
                busy      <= 1'b0;
                pkt_abort <= 1'b1;
                wcnt      <= '0;
                issued    <= '0;
                received  <= '0;
                total     <= '0;
                par_acc   <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (vld_out) begin
                            busy     <= 1'b1;
                            issued   <= '0;
                            received <= '0;
                            total    <= CNT_W'(2);
                            if (WAIT_CYCLES == 0) begin
                                state    <= ST_READ;
                                read_enb <= 1'b1;
                            end else begin
                                state <= ST_WAIT;
                                wcnt  <= WCNT_W'(WAIT_CYCLES);
                            end
                        end
                    end

                    ST_WAIT: begin
                        if (!vld_out) begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                            wcnt  <= '0;
                        end else if (wcnt <= WCNT_W'(1)) begin
                            state    <= ST_READ;
                            read_enb <= 1'b1;
                            wcnt     <= '0;
                        end else begin
                            wcnt <= wcnt - WCNT_W'(1);
                        end
                    end

                    ST_READ: begin
                        issued   <= issued_n;
                        received <= received_n;
                        total    <= total_n;
                        if (rx_valid) begin
                            if (hdr_now) begin
                                pkt_len    <= data_out[HDR_LEN_MSB:HDR_LEN_LSB];
                                addr       <= data_out[HDR_ADDR_MSB:HDR_ADDR_LSB];
                                par_acc    <= data_out;
                                parity_err <= 1'b0;
                                addr_err   <= 1'b0;
                            end else if (received_n == total_n) begin
                                par_byte <= data_out;
                            end else begin
                                par_acc <= par_acc ^ data_out;
                            end
                        end
                        if (rx_valid && (received_n == total_n)) begin
                            state    <= ST_DONE;
                            read_enb <= 1'b0;
                        end else begin
                            read_enb <= vld_out && (issued_n < total_n);
                        end
                    end

                    ST_DONE: begin
                        state      <= ST_IDLE;
                        busy       <= 1'b0;
                        pkt_done   <= 1'b1;
                        parity_err <= (par_acc != par_byte);
                        addr_err   <= (addr != ADDR_W'(MY_ADDR));
                        issued     <= '0;
                        received   <= '0;
                        total      <= '0;
                    end

                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_router_dest_reader.sv
// Bench for router_dest_reader: behavioural FIFO plus a packet-level model
// of the expected byte stream, read count and status flags.
module tb_router_dest_reader;

    localparam int unsigned MY_ADDR = 0;

    logic       clk = 1'b0;
    logic       resetn;
    logic       vld_out;
    logic       soft_reset;
    logic [7:0] data_out;
    logic       read_enb;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [5:0] pkt_len;
    logic       busy;
    logic       pkt_done;
    logic       pkt_abort;
    logic       parity_err;
    logic       addr_err;

    router_dest_reader #(.DATA_W(8), .MY_ADDR(MY_ADDR), .WAIT_CYCLES(4)) dut (
        .clk(clk), .resetn(resetn), .vld_out(vld_out), .soft_reset(soft_reset),
        .data_out(data_out), .read_enb(read_enb), .rx_data(rx_data), .rx_valid(rx_valid),
        .pkt_len(pkt_len), .busy(busy), .pkt_done(pkt_done), .pkt_abort(pkt_abort),
        .parity_err(parity_err), .addr_err(addr_err)
    );

    always #5 clk = ~clk;

    logic [7:0] fifo_q[$];
    logic [7:0] pkt[$];
    logic [7:0] rx_got[$];
    logic [7:0] exp_stream[$];
    bit         dq_perr[$];
    bit         dq_aerr[$];
    logic [5:0] dq_len[$];
    bit         gate;
    int         n_re, cyc, first_re, n_abort;
    int         n_checks = 0;
    int         n_pass = 0;
    logic       s_re, s_abort, s_busy;

    // One clock of sampling (negedge) and FIFO response (just after posedge).
    task automatic step();
        @(negedge clk);
        s_re    = read_enb;
        s_abort = pkt_abort;
        s_busy  = busy;
        if (read_enb) begin
            n_re++;
            if (first_re < 0) first_re = cyc;
        end
        if (rx_valid) rx_got.push_back(rx_data);
        if (pkt_done) begin
            dq_perr.push_back(parity_err);
            dq_aerr.push_back(addr_err);
            dq_len.push_back(pkt_len);
        end
        if (pkt_abort) n_abort++;
        cyc++;
        @(posedge clk);
        #1;
        if (s_re) begin
            if (fifo_q.size() > 0) data_out = fifo_q.pop_front();
            else data_out = 8'hEE;
        end
        vld_out = gate && (fifo_q.size() > 0);
    endtask

    task automatic make_pkt(input int len, input int addr, input bit corrupt);
        logic [7:0] h, x, b;
        h = {6'(len), 2'(addr)};
        pkt.delete();
        pkt.push_back(h);
        x = h;
        for (int i = 0; i < len; i++) begin
            b = 8'($urandom);
            pkt.push_back(b);
            x ^= b;
        end
        pkt.push_back(corrupt ? ~x : x);
    endtask

    // Packet-level expectation straight from the header/parity rules.
    task automatic model_expect(output logic [5:0] l, output bit pe, output bit ae);
        logic [7:0] h, x;
        int n;
        h = pkt[0];
        l = h[7:2];
        n = int'(l);
        x = 8'h00;
        for (int i = 0; i <= n; i++) x ^= pkt[i];
        pe = (x != pkt[n+1]);
        ae = (h[1:0] != 2'(MY_ADDR));
    endtask

    task automatic load_pkt();
        foreach (pkt[i]) fifo_q.push_back(pkt[i]);
        vld_out = gate && (fifo_q.size() > 0);
    endtask

    task automatic run_pkt(input string name, input int stall_at);
        logic [5:0] l;
        bit pe, ae, stalled, to;
        int d0, a0, m, bad;
        model_expect(l, pe, ae);
        n_re = 0; rx_got.delete(); first_re = -1; cyc = 0;
        d0 = dq_perr.size(); a0 = n_abort;
        stalled = 0; to = 1;
        load_pkt();
        for (int i = 0; i < 300; i++) begin
            step();
            if (stall_at >= 0 && !stalled && n_re == stall_at) begin
                stalled = 1;
                gate = 0; vld_out = 0;
                step();
                m = n_re;
                step(); step(); step();
                n_checks++;
                if (n_re !== m) $display("FAIL %s stall_reads: got %0d expected %0d", name, n_re, m);
                else n_pass++;
                gate = 1; vld_out = (fifo_q.size() > 0);
            end
            if (dq_perr.size() > d0) begin to = 0; break; end
        end
        n_checks++;
        if (to) $display("FAIL %s timeout: got no pkt_done expected pkt_done", name);
        else n_pass++;
        n_checks++;
        if (n_re !== int'(l) + 2) $display("FAIL %s reads: got %0d expected %0d", name, n_re, int'(l) + 2);
        else n_pass++;
        bad = 0;
        if (rx_got.size() != pkt.size()) bad = -1;
        else foreach (pkt[i]) if (rx_got[i] !== pkt[i]) bad++;
        n_checks++;
        if (bad != 0) $display("FAIL %s rx_stream: got %0d bytes (%0d wrong) expected %0d bytes", name, rx_got.size(), bad, pkt.size());
        else n_pass++;
        if (!to) begin
            n_checks++;
            if ({dq_perr[d0], dq_aerr[d0], dq_len[d0]} !== {pe, ae, l})
                $display("FAIL %s status: got perr=%0d aerr=%0d len=%0d expected perr=%0d aerr=%0d len=%0d",
                         name, dq_perr[d0], dq_aerr[d0], dq_len[d0], pe, ae, l);
            else n_pass++;
            n_checks++;
            if (s_busy !== 1'b0) $display("FAIL %s busy_after_done: got %0d expected 0", name, s_busy);
            else n_pass++;
        end
        n_checks++;
        if (n_abort !== a0) $display("FAIL %s spurious_abort: got %0d expected %0d", name, n_abort, a0);
        else n_pass++;
    endtask

    task automatic test_reset();
        resetn = 0; vld_out = 0; soft_reset = 0; data_out = 8'h00; gate = 1;
        n_abort = 0; first_re = -1; cyc = 0; n_re = 0;
        step(); step();
        n_checks++;
        if ({read_enb, rx_valid, rx_data, pkt_len, busy, pkt_done, pkt_abort, parity_err, addr_err} !== '0)
            $display("FAIL reset_outputs: got re=%0d rxv=%0d rxd=%0h len=%0d busy=%0d done=%0d abort=%0d pe=%0d ae=%0d expected all 0",
                     read_enb, rx_valid, rx_data, pkt_len, busy, pkt_done, pkt_abort, parity_err, addr_err);
        else n_pass++;
        resetn = 1;
        step();
        soft_reset = 1;
        step();
        soft_reset = 0;
        step(); step();
        n_checks++;
        if (n_abort !== 0 || s_busy !== 1'b0) $display("FAIL idle_soft_reset: got aborts=%0d busy=%0d expected 0 0", n_abort, s_busy);
        else n_pass++;
    endtask

    task automatic test_basic();
        pkt.delete();
        pkt.push_back(8'h0C); pkt.push_back(8'h11); pkt.push_back(8'h22); pkt.push_back(8'h33);
        pkt.push_back(8'h0C ^ 8'h11 ^ 8'h22 ^ 8'h33);
        run_pkt("basic", -1);
        n_checks++;
        if (first_re !== 5) $display("FAIL basic_latency: got %0d expected 5", first_re);
        else n_pass++;
        pkt[4] = 8'h00;
        run_pkt("parity_err", -1);
        make_pkt(1, 1, 0);
        run_pkt("addr_err", -1);
        pkt.delete(); pkt.push_back(8'h00); pkt.push_back(8'h00);
        run_pkt("len0", -1);
    endtask

    task automatic test_stall();
        make_pkt(6, 0, 0);
        run_pkt("stall", 3);
    endtask

    task automatic test_back_to_back();
        logic [5:0] l1, l2;
        bit pe1, ae1, pe2, ae2, to;
        int d0, bad;
        make_pkt($urandom_range(0, 12), 0, 0);
        model_expect(l1, pe1, ae1);
        exp_stream = pkt;
        load_pkt();
        make_pkt($urandom_range(0, 12), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        model_expect(l2, pe2, ae2);
        foreach (pkt[i]) exp_stream.push_back(pkt[i]);
        n_re = 0; rx_got.delete(); d0 = dq_perr.size(); to = 1;
        load_pkt();
        for (int i = 0; i < 400; i++) begin
            step();
            if (dq_perr.size() >= d0 + 2) begin to = 0; break; end
        end
        n_checks++;
        if (to) $display("FAIL b2b timeout: got %0d done expected 2", dq_perr.size() - d0);
        else n_pass++;
        n_checks++;
        if (n_re !== int'(l1) + int'(l2) + 4) $display("FAIL b2b reads: got %0d expected %0d", n_re, int'(l1) + int'(l2) + 4);
        else n_pass++;
        bad = 0;
        if (rx_got.size() != exp_stream.size()) bad = -1;
        else foreach (exp_stream[i]) if (rx_got[i] !== exp_stream[i]) bad++;
        n_checks++;
        if (bad != 0) $display("FAIL b2b rx_stream: got %0d bytes (%0d wrong) expected %0d bytes", rx_got.size(), bad, exp_stream.size());
        else n_pass++;
        if (!to) begin
            n_checks++;
            if ({dq_perr[d0], dq_aerr[d0], dq_len[d0], dq_perr[d0+1], dq_aerr[d0+1], dq_len[d0+1]} !== {pe1, ae1, l1, pe2, ae2, l2})
                $display("FAIL b2b status: got %0d/%0d/%0d %0d/%0d/%0d expected %0d/%0d/%0d %0d/%0d/%0d",
                         dq_perr[d0], dq_aerr[d0], dq_len[d0], dq_perr[d0+1], dq_aerr[d0+1], dq_len[d0+1],
                         pe1, ae1, l1, pe2, ae2, l2);
            else n_pass++;
        end
    endtask

    task automatic test_soft_reset();
        int d0, a0;
        bit to;
        make_pkt(10, 0, 0);
        n_re = 0; rx_got.delete(); d0 = dq_perr.size(); a0 = n_abort; to = 1;
        load_pkt();
        for (int i = 0; i < 100; i++) begin
            step();
            if (rx_got.size() >= 3) begin to = 0; break; end
        end
        n_checks++;
        if (to) $display("FAIL abort_setup timeout: got %0d bytes expected 3", rx_got.size());
        else n_pass++;
        soft_reset = 1; fifo_q.delete(); vld_out = 0;
        step();
        soft_reset = 0;
        step();
        n_checks++;
        if ({s_re, s_abort, s_busy} !== 3'b010)
            $display("FAIL abort_response: got re=%0d abort=%0d busy=%0d expected 0 1 0", s_re, s_abort, s_busy);
        else n_pass++;
        repeat (6) step();
        n_checks++;
        if (dq_perr.size() !== d0 || n_abort !== a0 + 1)
            $display("FAIL abort_pulses: got done=%0d abort=%0d expected done=0 abort=1", dq_perr.size() - d0, n_abort - a0);
        else n_pass++;
        make_pkt(4, 0, 0);
        run_pkt("post_abort", -1);
    endtask

    task automatic test_async_reset();
        make_pkt(8, 0, 0);
        n_re = 0;
        load_pkt();
        for (int i = 0; i < 100 && n_re < 4; i++) step();
        resetn = 0;
        #1;
        n_checks++;
        if ({read_enb, rx_valid, busy, pkt_done, pkt_abort, parity_err, addr_err, pkt_len} !== '0)
            $display("FAIL async_reset: got re=%0d rxv=%0d busy=%0d len=%0d expected all 0", read_enb, rx_valid, busy, pkt_len);
        else n_pass++;
        fifo_q.delete(); vld_out = 0; data_out = 8'h00;
        step(); step();
        resetn = 1;
        step();
        make_pkt(5, 0, 0);
        run_pkt("post_reset", -1);
    endtask

    task automatic test_random();
        int len;
        for (int k = 0; k < 8; k++) begin
            len = $urandom_range(0, 20);
            make_pkt(len, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
            run_pkt("random", (len >= 3 && $urandom_range(0, 1) == 1) ? 2 : -1);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_back_to_back();
        test_soft_reset();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
